// File: rtl/meteor_pkg.sv
// Shared definitions for the meteor field: LFSR feedback mask, default hide
// position, slot record, and the ammo-versus-slot hit test.
package meteor_pkg;

   localparam logic [15:0] LFSR_MASK  = 16'hB400;
   localparam int          X_HIDE_DEF = 700;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] speed;
      logic       active;
   } slot_t;

   // Ammo point inside the slot box, with the box stretched downward by the
   // ammo half-height. Everything is widened to 11 bits so the upper bounds
   // never wrap.
   function automatic logic hit_test(
      input logic        ammo_valid,
      input logic [9:0]  ammo_x,
      input logic [9:0]  ammo_y,
      input logic [9:0]  ammo_size,
      input slot_t       s,
      input logic [10:0] size
   );
      logic [10:0] ax;
      logic [10:0] ay;
      logic [10:0] x_hi;
      logic [10:0] y_hi;
      ax   = {1'b0, ammo_x};
      ay   = {1'b0, ammo_y};
      x_hi = {1'b0, s.x} + size;
      y_hi = {1'b0, s.y} + size + {1'b0, ammo_size};
      return ammo_valid && s.active &&
             (ax >= {1'b0, s.x}) && (ax < x_hi) &&
             (ay >= {1'b0, s.y}) && (ay < y_hi);
   endfunction

endpackage

// File: rtl/meteor_field_if.sv
// Bus between the meteor field and the game side: ammo position in,
// per-slot sprite data and game events out.
// METEOR_LEVEL_EN adds the 2-bit difficulty level output.
interface meteor_field_if #(
   parameter int NUM_OBJ = 8
);
   logic               ammo_valid;
   logic [9:0]         ammo_x;
   logic [9:0]         ammo_y;
   logic [9:0]         ammo_size;
   logic [9:0]         obj_x    [NUM_OBJ];
   logic [9:0]         obj_y    [NUM_OBJ];
   logic [9:0]         obj_size [NUM_OBJ];
   logic [NUM_OBJ-1:0] obj_active;
   logic               bullet_hit;
   logic [3:0]         hit_index;
   logic               escaped;
   logic [15:0]        hit_count;
`ifdef METEOR_LEVEL_EN
   logic [1:0]         level;
`endif

   modport master (
      output ammo_valid, ammo_x, ammo_y, ammo_size,
      input  obj_x, obj_y, obj_size, obj_active,
      input  bullet_hit, hit_index, escaped, hit_count
`ifdef METEOR_LEVEL_EN
      , input level
`endif
   );

   modport slave (
      input  ammo_valid, ammo_x, ammo_y, ammo_size,
      output obj_x, obj_y, obj_size, obj_active,
      output bullet_hit, hit_index, escaped, hit_count
`ifdef METEOR_LEVEL_EN
      , output level
`endif
   );
endinterface

// File: rtl/meteor_field_lfsr.sv
// 16-bit right-shifting Galois LFSR; advances only on enabled frames.
module meteor_lfsr
   import meteor_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic        enable,
   output logic [15:0] value
);

   // Shift right; when the bit falling out is 1, fold in the feedback mask.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset)
         value <= SEED;
      else if (enable)
         value <= value[0] ? ((value >> 1) ^ LFSR_MASK) : (value >> 1);
   end

endmodule

// File: rtl/meteor_field.sv
// N-slot meteor manager: spawns meteors at pseudo-random X and speed, moves
// them down once per frame, and frees them on an ammo hit or at the bottom.
// METEOR_LEVEL_EN adds a difficulty level that shortens the spawn interval
// and speeds up new meteors every 16 hits.
module meteor_field
   import meteor_pkg::*;
#(
   parameter int          NUM_OBJ        = 8,
   parameter int          OBJ_SIZE       = 30,
   parameter int          X_MIN          = 5,
   parameter int          Y_MIN          = 3,
   parameter int          Y_MAX          = 476,
   parameter int          X_HIDE         = X_HIDE_DEF,
   parameter int          SPAWN_INTERVAL = 32,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic          frame_clk,
   input  logic          Reset,
   input  logic          enable,
   meteor_field_if.slave bus
);

   // One spare bit so the counter also covers the level-mode floor of 4.
   localparam int         CNT_W      = $clog2((SPAWN_INTERVAL > 4) ? SPAWN_INTERVAL : 4) + 1;
   localparam logic [9:0] X_HIDE_V   = 10'(X_HIDE);
   localparam logic [9:0] Y_MIN_V    = 10'(Y_MIN);
   localparam logic [9:0] X_MIN_V    = 10'(X_MIN);
   localparam logic [10:0] SIZE_V    = 11'(OBJ_SIZE);
   localparam logic [10:0] Y_MAX_V   = 11'(Y_MAX);

   slot_t            slots     [NUM_OBJ];
   slot_t            slots_nxt [NUM_OBJ];
   logic [15:0]      lfsr;
   logic [CNT_W-1:0] spawn_cnt;
   logic [CNT_W-1:0] spawn_cnt_nxt;
   logic [CNT_W-1:0] interval_m1;
   logic             spawn_now;
   logic             hit_take;
   logic [3:0]       hit_sel;
   logic             free_any;
   logic [3:0]       free_sel;
   logic             esc_any;
   logic [10:0]      bottom;
   logic [2:0]       speed_bonus;
   logic             hit_pulse;
   logic [3:0]       hit_index_q;
   logic             esc_pulse;
   logic [15:0]      hit_count_q;
   logic [15:0]      hit_count_nxt;
   logic             unused_lfsr;

   assign unused_lfsr = ^lfsr[15:11];

   meteor_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .enable    (enable),
      .value     (lfsr)
   );

`ifdef METEOR_LEVEL_EN
   logic [1:0] level;
   logic [1:0] level_nxt;

   // Interval shrinks by 8 frames per level but never below 4.
   always_comb begin
      int eff;
      eff = SPAWN_INTERVAL - 8 * int'(level);
      if (eff < 4)
         eff = 4;
      interval_m1 = CNT_W'(eff - 1);
   end

   assign speed_bonus = {1'b0, level};

   // Level steps when the hit counter's low nibble rolls over.
   always_comb begin
      level_nxt = level;
      if (hit_take && (hit_count_q != 16'hFFFF) && (hit_count_q[3:0] == 4'hF) && (level != 2'd3))
         level_nxt = level + 2'd1;
   end

   assign bus.level = level;
`else
   assign interval_m1 = CNT_W'(SPAWN_INTERVAL - 1);
   assign speed_bonus = 3'd0;
`endif

   // Priority encoders: lowest-index hit slot and lowest-index free slot,
   // both judged on the pre-edge slot state.
   always_comb begin
      hit_take = 1'b0;
      hit_sel  = 4'd0;
      free_any = 1'b0;
      free_sel = 4'd0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (!hit_take && hit_test(bus.ammo_valid, bus.ammo_x, bus.ammo_y,
                                   bus.ammo_size, slots[i], SIZE_V)) begin
            hit_take = 1'b1;
            hit_sel  = 4'(i);
         end
         if (!free_any && !slots[i].active) begin
            free_any = 1'b1;
            free_sel = 4'(i);
         end
      end
   end

   assign spawn_now     = (spawn_cnt >= interval_m1);
   assign spawn_cnt_nxt = spawn_now ? '0 : spawn_cnt + 1'b1;
   assign hit_count_nxt = (hit_take && (hit_count_q != 16'hFFFF)) ? hit_count_q + 16'd1 : hit_count_q;

   // Per-slot next state: hit beats bottom; a slot freed this frame is not a
   // spawn candidate because the free slot was picked from pre-edge state.
   always_comb begin
      esc_any = 1'b0;
      bottom  = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         slots_nxt[i] = slots[i];
         if (hit_take && (hit_sel == 4'(i))) begin
            slots_nxt[i].active = 1'b0;
            slots_nxt[i].x      = X_HIDE_V;
         end else if (slots[i].active) begin
            bottom = {1'b0, slots[i].y} + SIZE_V + {8'd0, slots[i].speed};
            if (bottom > Y_MAX_V) begin
               slots_nxt[i].active = 1'b0;
               slots_nxt[i].x      = X_HIDE_V;
               slots_nxt[i].y      = Y_MIN_V;
               esc_any             = 1'b1;
            end else begin
               slots_nxt[i].y = slots[i].y + {7'd0, slots[i].speed};
            end
         end else if (spawn_now && free_any && (free_sel == 4'(i))) begin
            slots_nxt[i].x      = X_MIN_V + {1'b0, lfsr[8:0]};
            slots_nxt[i].y      = Y_MIN_V;
            slots_nxt[i].speed  = {1'b0, lfsr[10:9]} + 3'd1 + speed_bonus;
            slots_nxt[i].active = 1'b1;
         end
      end
   end

   // State registers; a disabled frame holds everything and drops the pulses.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_OBJ; i++)
            slots[i] <= '{x: X_HIDE_V, y: Y_MIN_V, speed: 3'd0, active: 1'b0};
         spawn_cnt   <= '0;
         hit_pulse   <= 1'b0;
         hit_index_q <= 4'd0;
         esc_pulse   <= 1'b0;
         hit_count_q <= 16'd0;
`ifdef METEOR_LEVEL_EN
         level       <= 2'd0;
`endif
      end else if (enable) begin
         for (int i = 0; i < NUM_OBJ; i++)
            slots[i] <= slots_nxt[i];
         spawn_cnt   <= spawn_cnt_nxt;
         hit_pulse   <= hit_take;
         if (hit_take)
            hit_index_q <= hit_sel;
         esc_pulse   <= esc_any;
         hit_count_q <= hit_count_nxt;
`ifdef METEOR_LEVEL_EN
         level       <= level_nxt;
`endif
      end else begin
         hit_pulse <= 1'b0;
         esc_pulse <= 1'b0;
      end
   end

   // Sprite outputs straight from the slot registers.
   always_comb begin
      for (int i = 0; i < NUM_OBJ; i++) begin
         bus.obj_x[i]      = slots[i].x;
         bus.obj_y[i]      = slots[i].y;
         bus.obj_size[i]   = SIZE_V[9:0];
         bus.obj_active[i] = slots[i].active;
      end
   end

   assign bus.bullet_hit = hit_pulse;
   assign bus.hit_index  = hit_index_q;
   assign bus.escaped    = esc_pulse;
   assign bus.hit_count  = hit_count_q;

endmodule
